// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector uop sequencer and its per-uop field calculator.
package rv32v_types_pkg;

  typedef struct packed {
    logic [1:0] unit;
    logic [5:0] op;
  } vexec_t;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    WIDEN   = 2'd1,
    NARROW  = 2'd2,
    MASKDST = 2'd3
  } uop_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } uop_state_t;

  // Element index fields depend on VLEN, so they travel beside this struct.
  typedef struct packed {
    vexec_t     vexec;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic       half;
    logic       first;
    logic       last;
  } uop_t;

  function automatic logic is_halved(input uop_mode_t mode);
    return (mode == WIDEN) || (mode == NARROW);
  endfunction

endpackage

// File: rtl/rv32v_uop_calc.sv
// Combinational mapping of (bases, mode, uop index, epu, vl) to one uop's fields.
module rv32v_uop_calc
  import rv32v_types_pkg::*;
#(
  parameter int VLW = 8,
  parameter int IW  = 4
) (
  input  vexec_t           i_vexec,
  input  logic [4:0]       i_vd,
  input  logic [4:0]       i_vs1,
  input  logic [4:0]       i_vs2,
  input  uop_mode_t        i_mode,
  input  logic [IW-1:0]    i_idx,
  input  logic [IW-1:0]    i_last_idx,
  input  logic [VLW-1:0]   i_vl,
  input  logic [4:0]       i_epu_sh,
  output uop_t             o_uop,
  output logic [VLW-1:0]   o_start,
  output logic [VLW-1:0]   o_count
);

  localparam logic [VLW-1:0] ONE = {{(VLW-1){1'b0}}, 1'b1};

  logic [4:0]     w_idx;
  logic [4:0]     w_pair;
  logic [VLW-1:0] w_epu;
  logic [VLW-1:0] w_rem;

  // epu is a power of two, so start = idx*epu is a shift; 5-bit adds wrap mod 32
  always_comb begin
    w_idx       = 5'(i_idx);
    w_pair      = w_idx >> 1;
    w_epu       = ONE << i_epu_sh;
    o_start     = VLW'(i_idx) << i_epu_sh;
    w_rem       = i_vl - o_start;
    o_count     = (w_rem < w_epu) ? w_rem : w_epu;
    o_uop.vexec = i_vexec;
    o_uop.first = (i_idx == {IW{1'b0}});
    o_uop.last  = (i_idx == i_last_idx);
    case (i_mode)
      WIDEN: begin
        o_uop.vd   = i_vd + w_idx;
        o_uop.vs1  = i_vs1 + w_pair;
        o_uop.vs2  = i_vs2 + w_pair;
        o_uop.half = w_idx[0];
      end
      NARROW: begin
        o_uop.vd   = i_vd + w_pair;
        o_uop.vs1  = i_vs1 + w_pair;
        o_uop.vs2  = i_vs2 + w_idx;
        o_uop.half = w_idx[0];
      end
      MASKDST: begin
        o_uop.vd   = i_vd;
        o_uop.vs1  = i_vs1 + w_idx;
        o_uop.vs2  = i_vs2 + w_idx;
        o_uop.half = 1'b0;
      end
      default: begin
        o_uop.vd   = i_vd + w_idx;
        o_uop.vs1  = i_vs1 + w_idx;
        o_uop.vs2  = i_vs2 + w_idx;
        o_uop.half = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32v_uop_sequencer.sv
// Splits a decoded vector instruction into per-register uops with valid/ready on both sides.
// Optional macro RV32V_UOP_BYPASS_EN accepts the next instruction on the last uop handshake.
module rv32v_uop_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int MAX_UOPS = 16,
  parameter int VLW      = $clog2(VLEN) + 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  vexec_t         in_vexec,
  input  logic [4:0]     in_vd,
  input  logic [4:0]     in_vs1,
  input  logic [4:0]     in_vs2,
  input  logic [1:0]     in_vsew,
  input  logic [VLW-1:0] in_vl,
  input  uop_mode_t      in_mode,
  output logic           uop_valid,
  input  logic           uop_ready,
  output vexec_t         uop_vexec,
  output logic [4:0]     uop_vd,
  output logic [4:0]     uop_vs1,
  output logic [4:0]     uop_vs2,
  output logic           uop_half,
  output logic [VLW-1:0] uop_start,
  output logic [VLW-1:0] uop_count,
  output logic           uop_first,
  output logic           uop_last,
  output logic           empty_done
);

  localparam int            IW      = $clog2(MAX_UOPS);
  localparam logic [4:0]    EPR_SH  = 5'($clog2(VLEN / 8));
  localparam logic [VLW:0]  VL_ONE  = {{VLW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

  uop_state_t     r_state;
  logic [IW-1:0]  r_idx, r_last_idx;
  logic [4:0]     r_vd, r_vs1, r_vs2, r_sh;
  uop_mode_t      r_mode;
  logic [VLW-1:0] r_vl, r_start, r_count;
  uop_t           r_uop;
  logic           r_valid, r_empty_done;

  logic           w_accept;
  logic [4:0]     w_in_sh;
  logic [VLW:0]   w_in_nuops;
  logic [IW-1:0]  w_in_last;
  vexec_t         w_c_vexec;
  logic [4:0]     w_c_vd, w_c_vs1, w_c_vs2, w_c_sh;
  uop_mode_t      w_c_mode;
  logic [IW-1:0]  w_c_idx, w_c_last;
  logic [VLW-1:0] w_c_vl, w_start, w_count;
  uop_t           w_uop;

`ifdef RV32V_UOP_BYPASS_EN
  assign in_ready = (r_state == IDLE) || ((r_state == ISSUE) && r_uop.last && uop_ready);
`else
  assign in_ready = (r_state == IDLE);
`endif

  assign w_accept = in_valid && in_ready && !flush;

  // On acceptance the calculator sees the incoming fields and uop 0, otherwise the next latched uop
  always_comb begin
    w_in_sh    = EPR_SH - {3'b000, in_vsew} - {4'b0000, is_halved(in_mode)};
    w_in_nuops = ({1'b0, in_vl} + (VL_ONE << w_in_sh) - VL_ONE) >> w_in_sh;
    w_in_last  = IW'(w_in_nuops - VL_ONE);
    w_c_vexec  = w_accept ? in_vexec  : r_uop.vexec;
    w_c_vd     = w_accept ? in_vd     : r_vd;
    w_c_vs1    = w_accept ? in_vs1    : r_vs1;
    w_c_vs2    = w_accept ? in_vs2    : r_vs2;
    w_c_mode   = w_accept ? in_mode   : r_mode;
    w_c_vl     = w_accept ? in_vl     : r_vl;
    w_c_sh     = w_accept ? w_in_sh   : r_sh;
    w_c_last   = w_accept ? w_in_last : r_last_idx;
    w_c_idx    = w_accept ? {IW{1'b0}} : (r_idx + IDX_ONE);
  end

  rv32v_uop_calc #(.VLW(VLW), .IW(IW)) u_calc (
    .i_vexec    (w_c_vexec),
    .i_vd       (w_c_vd),
    .i_vs1      (w_c_vs1),
    .i_vs2      (w_c_vs2),
    .i_mode     (w_c_mode),
    .i_idx      (w_c_idx),
    .i_last_idx (w_c_last),
    .i_vl       (w_c_vl),
    .i_epu_sh   (w_c_sh),
    .o_uop      (w_uop),
    .o_start    (w_start),
    .o_count    (w_count)
  );

  // Sequencer FSM; flush outranks everything but reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_idx        <= {IW{1'b0}};
      r_last_idx   <= {IW{1'b0}};
      r_vd         <= 5'd0;
      r_vs1        <= 5'd0;
      r_vs2        <= 5'd0;
      r_sh         <= 5'd0;
      r_mode       <= NORMAL;
      r_vl         <= {VLW{1'b0}};
      r_uop        <= '0;
      r_start      <= {VLW{1'b0}};
      r_count      <= {VLW{1'b0}};
      r_valid      <= 1'b0;
      r_empty_done <= 1'b0;
    end else if (flush) begin
      r_state      <= IDLE;
      r_idx        <= {IW{1'b0}};
      r_valid      <= 1'b0;
      r_empty_done <= 1'b0;
    end else begin
      r_empty_done <= 1'b0;
      if (w_accept) begin
        r_vd       <= in_vd;
        r_vs1      <= in_vs1;
        r_vs2      <= in_vs2;
        r_mode     <= in_mode;
        r_vl       <= in_vl;
        r_sh       <= w_in_sh;
        r_last_idx <= w_in_last;
        r_idx      <= {IW{1'b0}};
        r_uop      <= w_uop;
        r_start    <= w_start;
        r_count    <= w_count;
        if (in_vl == {VLW{1'b0}}) begin
          r_state      <= IDLE;
          r_valid      <= 1'b0;
          r_empty_done <= 1'b1;
        end else begin
          r_state <= ISSUE;
          r_valid <= 1'b1;
        end
      end else if ((r_state == ISSUE) && uop_ready) begin
        if (r_uop.last) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end else begin
          r_idx   <= r_idx + IDX_ONE;
          r_uop   <= w_uop;
          r_start <= w_start;
          r_count <= w_count;
        end
      end
    end
  end

  assign uop_valid  = r_valid;
  assign uop_vexec  = r_uop.vexec;
  assign uop_vd     = r_uop.vd;
  assign uop_vs1    = r_uop.vs1;
  assign uop_vs2    = r_uop.vs2;
  assign uop_half   = r_uop.half;
  assign uop_first  = r_uop.first;
  assign uop_last   = r_uop.last;
  assign uop_start  = r_start;
  assign uop_count  = r_count;
  assign empty_done = r_empty_done;

endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Self-checking bench for rv32v_uop_sequencer: vector table plus a uop scoreboard.
module tb_rv32v_uop_sequencer;
  import rv32v_types_pkg::*;

  localparam int VLW = 8;
`ifdef RV32V_UOP_BYPASS_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1, flush = 1'b0, in_valid = 1'b0, uop_ready = 1'b1;
  logic           in_ready, uop_valid, uop_half, uop_first, uop_last, empty_done;
  vexec_t         in_vexec = '0, uop_vexec;
  logic [4:0]     in_vd = 5'd0, in_vs1 = 5'd0, in_vs2 = 5'd0;
  logic [4:0]     uop_vd, uop_vs1, uop_vs2;
  logic [1:0]     in_vsew = 2'd0;
  logic [VLW-1:0] in_vl = 8'd0, uop_start, uop_count;
  uop_mode_t      in_mode = NORMAL;

  always #5 CLK = ~CLK;

  rv32v_uop_sequencer #(.VLEN(128), .MAX_UOPS(16)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_vexec(in_vexec), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_vsew(in_vsew), .in_vl(in_vl), .in_mode(in_mode),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_vexec(uop_vexec),
    .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_half(uop_half),
    .uop_start(uop_start), .uop_count(uop_count), .uop_first(uop_first),
    .uop_last(uop_last), .empty_done(empty_done)
  );

  typedef struct {
    uop_mode_t  mode;
    logic [1:0] vsew;
    int         vl;
    logic [4:0] vd, vs1, vs2;
    int         exp_n;
    int         exp_last_cnt;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] sb_q [$];
  int total = 0, bad = 0, cyc = 0, hs_total = 0, valid_cycles = 0;
  int last_hs_cyc = 0, first_gap = 0, last_cnt = 0;
  logic accepted = 1'b0, stall_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input vexec_t vx, input logic [4:0] d, input logic [4:0] a,
                                     input logic [4:0] b, input logic h, input logic [7:0] s,
                                     input logic [7:0] c, input logic f, input logic l);
    return {22'd0, vx, d, a, b, h, s, c, f, l};
  endfunction

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [63:0] a;
    @(negedge CLK);
    a = pk(uop_vexec, uop_vd, uop_vs1, uop_vs2, uop_half, uop_start, uop_count, uop_first, uop_last);
    accepted = in_valid && in_ready && !flush && !RST;
    if (uop_valid) valid_cycles++;
    if (stall_chk) begin
      check("stall_valid", 64'(uop_valid), 64'd1);
      if (sb_q.size() > 0) check("stall_hold", a, sb_q[0]);
    end
    if (!RST && !flush && uop_valid && uop_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_uop: got=%0h expected=none", a);
      end else begin
        check("uop", a, sb_q.pop_front());
      end
      if (uop_first) first_gap = cyc - last_hs_cyc;
      if (uop_last) last_cnt = int'(uop_count);
      last_hs_cyc = cyc;
      hs_total++;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic model_push(input vexec_t vx, input uop_mode_t m, input logic [1:0] sew,
                            input int vl, input logic [4:0] vd, input logic [4:0] vs1,
                            input logic [4:0] vs2);
    int epr, epu, n, s, c;
    logic [4:0] d, a, b;
    logic h;
    epr = 16 >> sew;
    epu = (m == WIDEN || m == NARROW) ? epr / 2 : epr;
    n   = (vl + epu - 1) / epu;
    for (int i = 0; i < n; i++) begin
      s = i * epu;
      c = (vl - s < epu) ? vl - s : epu;
      h = 1'b0;
      case (m)
        WIDEN:   begin d = 5'(vd + i);     a = 5'(vs1 + i / 2); b = 5'(vs2 + i / 2); h = 1'(i % 2); end
        NARROW:  begin d = 5'(vd + i / 2); a = 5'(vs1 + i / 2); b = 5'(vs2 + i);     h = 1'(i % 2); end
        MASKDST: begin d = vd;             a = 5'(vs1 + i);     b = 5'(vs2 + i);     end
        default: begin d = 5'(vd + i);     a = 5'(vs1 + i);     b = 5'(vs2 + i);     end
      endcase
      sb_q.push_back(pk(vx, d, a, b, h, 8'(s), 8'(c), i == 0, i == n - 1));
    end
  endtask

  task automatic send(input vexec_t vx, input uop_mode_t m, input logic [1:0] sew, input int vl,
                      input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
    logic ok;
    in_vexec = vx; in_mode = m; in_vsew = sew; in_vl = 8'(vl);
    in_vd = vd; in_vs1 = vs1; in_vs2 = vs2;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      ok = accepted;
    end
    in_valid = 1'b0;
    if (ok) model_push(vx, m, sew, vl, vd, vs1, vs2);
    else begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=no_accept expected=accept");
    end
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (sb_q.size() == 0 && !uop_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=pending=%0d expected=0", sb_q.size());
    end
  endtask

  initial begin
    vexec_t vx;
    int base, vc;
    vecs[0] = '{NORMAL,  2'd2, 10,  5'd8,  5'd24, 5'd16, 3,  2};
    vecs[1] = '{WIDEN,   2'd1, 16,  5'd4,  5'd20, 5'd12, 4,  4};
    vecs[2] = '{NARROW,  2'd0, 20,  5'd2,  5'd6,  5'd10, 3,  4};
    vecs[3] = '{MASKDST, 2'd0, 33,  5'd0,  5'd30, 5'd31, 3,  1};
    vecs[4] = '{NORMAL,  2'd0, 128, 5'd0,  5'd8,  5'd16, 8,  16};
    vecs[5] = '{WIDEN,   2'd2, 32,  5'd16, 5'd8,  5'd0,  16, 2};
    vecs[6] = '{NORMAL,  2'd1, 1,   5'd31, 5'd31, 5'd31, 1,  1};

    // reset state
    repeat (2) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_uop_valid", 64'(uop_valid), 64'd0);
    check("rst_empty_done", 64'(empty_done), 64'd0);
    check("rst_fields", pk(uop_vexec, uop_vd, uop_vs1, uop_vs2, uop_half, uop_start, uop_count,
                           uop_first, uop_last), 64'd0);
    RST = 1'b0;
    tick();

    // table-driven instructions
    for (int v = 0; v < 7; v++) begin
      vx.unit = 2'(v);
      vx.op   = 6'(v * 5 + 1);
      base = hs_total;
      send(vx, vecs[v].mode, vecs[v].vsew, vecs[v].vl, vecs[v].vd, vecs[v].vs1, vecs[v].vs2);
      wait_done();
      check("n_uops", 64'(hs_total - base), 64'(vecs[v].exp_n));
      check("last_cnt", 64'(last_cnt), 64'(vecs[v].exp_last_cnt));
    end

    // vl=0 produces only an empty_done pulse
    vx = '{unit: 2'd3, op: 6'd7};
    base = hs_total;
    send(vx, NORMAL, 2'd0, 0, 5'd1, 5'd2, 5'd3);
    check("empty_pulse", 64'(empty_done), 64'd1);
    check("empty_no_valid", 64'(uop_valid), 64'd0);
    check("empty_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("empty_pulse_end", 64'(empty_done), 64'd0);
    check("empty_no_uops", 64'(hs_total - base), 64'd0);

    // backpressure on the 2nd uop for 5 cycles
    uop_ready = 1'b0;
    base = hs_total;
    send(vx, vecs[0].mode, vecs[0].vsew, vecs[0].vl, vecs[0].vd, vecs[0].vs1, vecs[0].vs2);
    uop_ready = 1'b1;
    tick();
    uop_ready = 1'b0;
    stall_chk = 1'b1;
    repeat (5) tick();
    stall_chk = 1'b0;
    uop_ready = 1'b1;
    wait_done();
    check("bp_n_uops", 64'(hs_total - base), 64'd3);

    // flush while the 2nd of 3 uops is on offer, with a new instruction presented
    base = hs_total;
    send(vx, vecs[0].mode, vecs[0].vsew, vecs[0].vl, vecs[0].vd, vecs[0].vs1, vecs[0].vs2);
    tick();
    flush = 1'b1;
    in_valid = 1'b1;
    in_vl = 8'd5;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(uop_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_squashed", 64'(sb_q.size()), 64'd2);
    sb_q.delete();
    vc = valid_cycles;
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (4) tick();
    check("flush_quiet", 64'(valid_cycles - vc), 64'd0);
    check("flush_n_uops", 64'(hs_total - base), 64'd1);
    send(vx, vecs[0].mode, vecs[0].vsew, vecs[0].vl, vecs[0].vd, vecs[0].vs1, vecs[0].vs2);
    wait_done();

    // back-to-back e8 vl=16 then vl=20
    send(vx, NORMAL, 2'd0, 16, 5'd1, 5'd2, 5'd3);
    send(vx, NORMAL, 2'd0, 20, 5'd5, 5'd6, 5'd7);
    wait_done();
    check("b2b_gap", 64'(first_gap), 64'(EXP_GAP));
    check("b2b_last_cnt", 64'(last_cnt), 64'd4);

    // reset while issuing
    send(vx, vecs[0].mode, vecs[0].vsew, vecs[0].vl, vecs[0].vd, vecs[0].vs1, vecs[0].vs2);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst2_valid", 64'(uop_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_fields", pk(uop_vexec, uop_vd, uop_vs1, uop_vs2, uop_half, uop_start, uop_count,
                            uop_first, uop_last), 64'd0);
    check("rst2_squashed", 64'(sb_q.size()), 64'd2);
    sb_q.delete();
    vc = valid_cycles;
    repeat (4) tick();
    check("rst2_quiet", 64'(valid_cycles - vc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
